mac_accumulator: RTL
====================

// Module: mac_accumulator
// PURPOSE
//  Multiply-accumulate stage downstream of the 32x32 unsigned array multiplier.
//  Accepts operand pairs over valid/ready, registers them into the multiplier,
//  registers the 64-bit product and sums products into a wide accumulator.
//  Presents the final sum after a 'last' beat; the result is held until it is consumed.
// PARAMETERS
//  ACC_W  72  accumulator/result width; legal range 64..128 (64 product bits + guard bits)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  clr        in   1      synchronous abort of the current accumulation
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      operand beat accepted when in_valid & in_ready
//  x, y       in   32     unsigned operands
//  last       in   1      qualifies the final beat of an accumulation
//  out_valid  out  1      result valid
//  out_ready  in   1      result consumed when out_valid & out_ready
//  acc_out    out  ACC_W  accumulated sum (unsigned)
//  term_cnt   out  16     terms accepted in current accumulation; saturates at 0xFFFF
//  ovf        out  1      sticky: accumulator exceeded 2^ACC_W-1
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; acc_out=0, term_cnt=0, ovf=0, out_valid=0;
//   pipeline valids=0. in_ready reads 1 in IDLE once rst_n=1.
//  FSM: IDLE -> RUN (first beat accepted, last=0); IDLE/RUN -> DRAIN (beat accepted with last=1);
//   DRAIN -> DONE (last product added); DONE -> IDLE (out handshake; acc, term_cnt, ovf cleared).
//  in_ready = 1 in IDLE/RUN, 0 in DRAIN/DONE, and 0 whenever clr=1.
//  Pipeline: beat accepted at edge N -> x_r/y_r at N; p_r = x_r*y_r at N+1;
//   acc += p_r at N+2. Back-to-back beats each cycle at full throughput.
//  Result latency: last accepted at edge N -> out_valid=1 after edge N+2.
//  DONE: acc_out, term_cnt, ovf stable while out_valid & !out_ready.
//  Arithmetic: unsigned. Product zero-extended to ACC_W. Carry out of ACC_W sets ovf.
//  clr=1 (any state): pipeline valids flushed, acc=0, term_cnt=0, ovf=0,
//   out_valid=0, state=IDLE next edge; clr has priority over in and out handshakes.
//  Single-term accumulation (first beat has last=1) is legal: IDLE -> DRAIN directly.
//  acc_out visible in RUN/DRAIN is the running partial sum; valid only with out_valid.
// CONFIGURATION
//  MAC_SATURATE_EN defined: on carry out acc clamps to all-ones and stays clamped;
//   ovf set.
//  Not defined: acc wraps modulo 2^ACC_W; ovf set, sticky.
// STRUCTURE
//  Shared header mac_defs.vh: FSM state localparams (IDLE, RUN, DRAIN, DONE, 2-bit),
//   TERM_CNT_W=16, operand width 32, product width 64.
//  Instantiates existing combinational multiplier Array_Mult32_gen unchanged.
//  One sub-module: mac_acc_stage (zero-extend, add, carry detect, wrap/saturate).
// TESTING
//  1. x=4,y=4,last=1 -> out_valid 3 cycles later, acc_out=0x10, term_cnt=1, ovf=0.
//  2. Beats (3,5),(7,9),(FFFFFFFF,FFFFFFFF,last) back-to-back -> acc_out=0xFFFFFFFE0000004F,
//     term_cnt=3.
//  3. Result pending, out_ready=0 for 5 cycles -> acc_out stable, in_ready=0, out_valid held;
//     out_ready=1 -> IDLE, acc_out=0.
//  4. ACC_W=64, two beats (FFFFFFFF,FFFFFFFF) -> ovf=1; acc_out=0xFFFFFFFC00000002
//     without macro, 0xFFFFFFFFFFFFFFFF with MAC_SATURATE_EN.
//  5. clr after 2 beats in flight -> no out_valid, term_cnt=0; then (2,3,last) -> acc_out=6.
//  6. rst_n low mid-DRAIN -> all outputs 0 immediately; after release in_ready=1,
//     next (4,4,last) -> 0x10.

Source files
------------

// File: rtl/mac_accumulator_pkg.sv
// rtl/mac_accumulator_pkg.sv - shared FSM states and datapath widths for the MAC accumulator
package mac_accumulator_pkg;

  localparam int OP_W       = 32;
  localparam int PROD_W     = 64;
  localparam int TERM_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

endpackage

// File: rtl/Array_Mult32_gen.sv
// rtl/Array_Mult32_gen.sv - combinational 32x32 unsigned array multiplier
module Array_Mult32_gen (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);

  // Sum of shifted partial products, one row per multiplier bit
  always_comb begin
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        p = p + ({32'b0, a} << i);
      end
    end
  end

endmodule

// File: rtl/mac_acc_stage.sv
// rtl/mac_acc_stage.sv - zero-extend product, add to accumulator, detect carry; MAC_SATURATE_EN selects clamp instead of wrap
import mac_accumulator_pkg::*;

module mac_acc_stage #(
  parameter int ACC_W = 72
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] sum_ext;

  // One extra bit on the adder captures the carry out of the accumulator
  always_comb begin
    sum_ext = {1'b0, acc} + (ACC_W+1)'(prod);
    carry   = sum_ext[ACC_W];
`ifdef MAC_SATURATE_EN
    // Clamp to all-ones; an all-ones accumulator only stays all-ones from here on
    sum     = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    // Wrap modulo 2^ACC_W; the overflow is still reported through carry
    sum     = sum_ext[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - pipelined multiply-accumulate with valid/ready operands and held result
import mac_accumulator_pkg::*;

module mac_accumulator #(
  parameter int ACC_W = 72
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       x,
  input  logic [OP_W-1:0]       y,
  input  logic                  last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      acc_out,
  output logic [TERM_CNT_W-1:0] term_cnt,
  output logic                  ovf
);

  mac_state_t state, state_nxt;

  logic              accept;
  logic              out_fire;
  logic [OP_W-1:0]   x_r, y_r;
  logic              v1, l1;
  logic [PROD_W-1:0] mult_p;
  logic [PROD_W-1:0] p_r;
  logic              v2, l2;
  logic [ACC_W-1:0]  acc_sum;
  logic              acc_carry;

  assign in_ready  = ((state == IDLE) || (state == RUN)) && !clr;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_fire  = out_valid && out_ready && !clr;

  Array_Mult32_gen u_mult (
    .a (x_r),
    .b (y_r),
    .p (mult_p)
  );

  mac_acc_stage #(.ACC_W(ACC_W)) u_acc_stage (
    .acc   (acc_out),
    .prod  (p_r),
    .sum   (acc_sum),
    .carry (acc_carry)
  );

  // Operand register stage feeding the multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r <= '0;
      y_r <= '0;
      v1  <= 1'b0;
      l1  <= 1'b0;
    end else if (clr) begin
      v1  <= 1'b0;
      l1  <= 1'b0;
    end else begin
      v1 <= accept;
      l1 <= accept && last;
      if (accept) begin
        x_r <= x;
        y_r <= y;
      end
    end
  end

  // Product register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r <= '0;
      v2  <= 1'b0;
      l2  <= 1'b0;
    end else if (clr) begin
      v2  <= 1'b0;
      l2  <= 1'b0;
    end else begin
      v2 <= v1;
      l2 <= l1;
      if (v1) begin
        p_r <= mult_p;
      end
    end
  end

  // Accumulator and sticky overflow; cleared on abort or once the result is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out <= '0;
      ovf     <= 1'b0;
    end else if (clr || out_fire) begin
      acc_out <= '0;
      ovf     <= 1'b0;
    end else if (v2) begin
      acc_out <= acc_sum;
      if (acc_carry) begin
        ovf <= 1'b1;
      end
    end
  end

  // Accepted-term counter, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_cnt <= '0;
    end else if (clr || out_fire) begin
      term_cnt <= '0;
    end else if (accept && (term_cnt != {TERM_CNT_W{1'b1}})) begin
      term_cnt <= term_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: abort wins over both handshakes
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt = last ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (accept && last) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (v2 && l2) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
